// File: rtl/scoreboard_register_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_NUM_READ   = 2;

  // PendingCount must hold the full depth (all registers busy), hence +1 bit.
  function automatic int unsigned countWidth(input int unsigned addrWidth);
    return addrWidth + 1;
  endfunction

  // LSB of read port 'port' inside a packed multi-port bus of 'width'-bit fields.
  function automatic int unsigned portLsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/scoreboard_register_file_if.sv
// Read, writeback, issue and status signals of the scoreboarded register file.
interface scoreboard_register_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister;
  logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
  logic [NUM_READ-1:0]            ReadBusy;
  logic [ADDR_WIDTH-1:0]          WriteRegister;
  logic [DATA_WIDTH-1:0]          WriteData;
  logic                           RegWrite;
  logic [ADDR_WIDTH-1:0]          IssueRegister;
  logic                           IssueValid;
  logic                           IssueReady;
  logic                           Flush;
  logic [ADDR_WIDTH:0]            PendingCount;

  modport master (
    output ReadRegister, WriteRegister, WriteData, RegWrite,
           IssueRegister, IssueValid, Flush,
    input  ReadData, ReadBusy, IssueReady, PendingCount
  );

  modport slave (
    input  ReadRegister, WriteRegister, WriteData, RegWrite,
           IssueRegister, IssueValid, Flush,
    output ReadData, ReadBusy, IssueReady, PendingCount
  );
endinterface

// File: rtl/scoreboard_register_file_busy_scoreboard.sv
// Per-register busy bits tracking in-flight producers, plus issue acceptance
// and a running count of busy registers.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1,
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH,
  localparam int unsigned CW        = countWidth(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] issueRegister,
  input  logic                  issueValid,
  input  logic                  flush,
  output logic [DEPTH-1:0]      busyVec,
  output logic                  issueReady,
  output logic [CW-1:0]         pendingCount
);

  logic            writeEff;
  logic            issueZero;
  logic            issueSet;
  logic            countInc;
  logic            countDec;
  logic [DEPTH-1:0] busyNext;
  logic [CW-1:0]    countNext;

  // Issue acceptance, next busy vector and count delta.
  always_comb begin
    writeEff   = regWrite & ~(ZERO_REG & (writeRegister == '0));
    issueZero  = ZERO_REG & (issueRegister == '0);
    issueReady = issueZero | ~busyVec[issueRegister] |
                 (regWrite & (writeRegister == issueRegister));
    issueSet   = issueValid & issueReady & ~flush & ~issueZero;
    // A write clearing a bit that the same-cycle issue re-sets is not a
    // release, so the count only moves when the bit's final value changes.
    countInc   = issueSet & ~busyVec[issueRegister];
    countDec   = writeEff & busyVec[writeRegister] &
                 ~(issueSet & (issueRegister == writeRegister));
    busyNext   = busyVec;
    if (writeEff) busyNext[writeRegister] = 1'b0;
    if (issueSet) busyNext[issueRegister] = 1'b1;
    countNext  = pendingCount + CW'(countInc) - CW'(countDec);
    if (flush) begin
      busyNext  = '0;
      countNext = '0;
    end
  end

  // Busy bits and pending count register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busyVec      <= '0;
      pendingCount <= '0;
    end else begin
      busyVec      <= busyNext;
      pendingCount <= countNext;
    end
  end

endmodule

// File: rtl/scoreboard_register_file.sv
// Parametrised multi-read-port register file with write-through bypass,
// optional hardwired zero register and busy scoreboard.
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_READ   = DEFAULT_NUM_READ,
  parameter bit          ZERO_REG   = 1'b1
) (
  input logic                        Clk,
  input logic                        Rst_n,
  scoreboard_register_file_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]               busyVec;
  logic                           writeEff;
  logic [NUM_READ*DATA_WIDTH-1:0] readDataVec;
  logic [NUM_READ-1:0]            readBusyVec;

  assign writeEff = bus.RegWrite & ~(ZERO_REG & (bus.WriteRegister == '0));

  // Data array: cleared on reset, written on writeback.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (writeEff) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  busy_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) uScoreboard (
    .clk           (Clk),
    .rstN          (Rst_n),
    .writeRegister (bus.WriteRegister),
    .regWrite      (bus.RegWrite),
    .issueRegister (bus.IssueRegister),
    .issueValid    (bus.IssueValid),
    .flush         (bus.Flush),
    .busyVec       (busyVec),
    .issueReady    (bus.IssueReady),
    .pendingCount  (bus.PendingCount)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : gRead
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  rdBusy;

    assign rdAddr = bus.ReadRegister[portLsb(i, ADDR_WIDTH) +: ADDR_WIDTH];

    // Per-port read mux: zero register, then writeback bypass, then array.
    always_comb begin
      rdData = regs[rdAddr];
      rdBusy = busyVec[rdAddr];
      if (ZERO_REG && rdAddr == '0) begin
        rdData = '0;
        rdBusy = 1'b0;
      end else if (bus.RegWrite && bus.WriteRegister == rdAddr) begin
        rdData = bus.WriteData;
        rdBusy = 1'b0;
      end
    end

    assign readDataVec[portLsb(i, DATA_WIDTH) +: DATA_WIDTH] = rdData;
    assign readBusyVec[i] = rdBusy;
  end

  assign bus.ReadData = readDataVec;
  assign bus.ReadBusy = readBusyVec;

endmodule
